// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master that streams bytes from a valid/ready source, MSB first,
// with a chip-select hold period and a minimum deselect gap between frames.
module spi_xfer_ctrl #(
    parameter int unsigned DIV = 4,
    parameter int unsigned GAP = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       spi_cs,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BIT_W  = 3;
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             phase_q, phase_d;
    logic [7:0]       tsr_q, tsr_d;
    logic [7:0]       rsr_q, rsr_d;
    logic             last_q, last_d;

    logic             tx_ready_q, tx_ready_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             busy_q, busy_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;

    logic             accept_c;

    assign accept_c = tx_valid && tx_ready_q;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            phase_q    <= 1'b0;
            tsr_q      <= '0;
            rsr_q      <= '0;
            last_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            busy_q     <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            phase_q    <= phase_d;
            tsr_q      <= tsr_d;
            rsr_q      <= rsr_d;
            last_q     <= last_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            busy_q     <= busy_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    // Next-state logic; outputs are derived from next-state values so they register in step
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        phase_d    = phase_q;
        tsr_d      = tsr_q;
        rsr_d      = rsr_q;
        last_d     = last_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    bit_d   = BIT_W'(7);
                    phase_d = 1'b0;
                    tsr_d   = tx_data;
                    mosi_d  = tx_data[7];
                    last_d  = tx_last;
                end
            end

            S_SETUP: begin
                if (cnt_q == DIV_M1) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SHIFT: begin
                if (cnt_q != DIV_M1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        rsr_d   = {rsr_q[6:0], spi_miso};
                    end else if (bit_q != '0) begin
                        phase_d = 1'b0;
                        bit_d   = bit_q - BIT_W'(1);
                        tsr_d   = {tsr_q[6:0], 1'b0};
                        mosi_d  = tsr_q[6];
                    end else begin
                        phase_d    = 1'b0;
                        rx_valid_d = 1'b1;
                        rx_data_d  = rsr_q;
                        if (last_q) begin
                            state_d = S_HOLD;
                        end else if (accept_c) begin
                            bit_d  = BIT_W'(7);
                            tsr_d  = tx_data;
                            mosi_d = tx_data[7];
                            last_d = tx_last;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end

            S_WAIT: begin
                if (accept_c) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = BIT_W'(7);
                    phase_d = 1'b0;
                    tsr_d   = tx_data;
                    mosi_d  = tx_data[7];
                    last_d  = tx_last;
                end
            end

            S_HOLD: begin
                if (cnt_q == DIV_M1) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_M1) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        sclk_d = (state_d == S_SHIFT) && phase_d;
        // CS releases one cycle into GAP so the deselect time, including the IDLE accept cycle, equals GAP
        cs_d   = (state_d == S_IDLE) || ((state_d == S_GAP) && (cnt_d != '0));
        tx_ready_d = (state_d == S_IDLE) || (state_d == S_WAIT) ||
                     ((state_d == S_SHIFT) && phase_d && (bit_d == '0) &&
                      (cnt_d == DIV_M1) && !last_d);
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign spi_cs   = cs_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;

endmodule
